round_sequencer: RTL and testbench
==================================

ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 SHALL have parameter BALLS, default 8: balls loaded per game, range 1..15.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 200_000_000: GET dwell in clk cycles, minimum 2.
REQ-003 SHALL have parameter LAUNCH_TIMEOUT, default 1_000_000_000: max START dwell in clk cycles, minimum 2.
REQ-004 SHALL have port clk  input  1  the only clock; all flops rise on its posedge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start_pulse  input  1  one-cycle, debounced start button pulse.
REQ-007 SHALL have port round_pulse  input  1  one-cycle, debounced round button pulse.
REQ-008 SHALL have port ball  input  8  raw level hole sensors, bit i = hole i.
REQ-009 SHALL have port state  output  3  0 RESET, 1 WAIT, 2 START, 3 GET, 4 OVER.
REQ-010 SHALL have port ball_num  output  4  balls remaining.
REQ-011 SHALL have port hit_valid  output  1  one-cycle pulse when a hole is latched.
REQ-012 SHALL have port hit_hole  output  3  index of the latched hole.
REQ-013 SHALL have port hit_mask  output  8  one-hot latched hole; zero when nothing is latched.
REQ-014 SHALL have port group_lock  output  1  high in START and GET; it freezes group selection.
REQ-015 SHALL have port timeout  output  1  one-cycle pulse when a launch times out.

Function
REQ-016 SHALL pass ball through a 2-flop synchronizer (sball); all decisions use sball; sensor-to-decision latency is 2 cycles.
REQ-017 SHALL move RESET->WAIT on start_pulse and load ball_num=BALLS on that same edge.
REQ-018 SHALL move WAIT->START on round_pulse only when sball==0; if sball!=0, round_pulse is ignored and the block stays in WAIT.
REQ-019 SHALL move START->GET on the first edge where sball!=0, performing these actions on that edge:
  - latch the lowest set index into hit_hole/hit_mask;
  - assert hit_valid for exactly one cycle;
  - decrement ball_num.
REQ-020 SHALL resolve simultaneous hits by the lowest index (fixed priority).
REQ-021 SHALL ignore all sensor activity in GET; hit_hole/hit_mask hold until the next START entry, which clears them to 0.
REQ-022 SHALL remain in GET for exactly SETTLE_CYCLES cycles, then move to WAIT if ball_num>0, else to OVER.
REQ-023 SHALL count START dwell. If LAUNCH_TIMEOUT cycles elapse with no hit, the following happen on one edge:
  - timeout pulses for one cycle;
  - ball_num decrements;
  - state moves to WAIT if the new ball_num>0, else to OVER.
REQ-024 SHALL give a hit priority over timeout when both occur on the same cycle.
REQ-025 SHALL move OVER->RESET on start_pulse; round_pulse is ignored in OVER and RESET.
REQ-026 SHALL ignore start_pulse in WAIT, START and GET.
REQ-027 SHALL saturate ball_num at 0 and never wrap.
REQ-028 SHALL clear the dwell counter on every state change; the counter is wide enough for the larger of SETTLE_CYCLES and LAUNCH_TIMEOUT without overflow.
REQ-029 SHALL drive state, ball_num, hit_* , group_lock and timeout from registers (no combinational input-to-output path).
REQ-030 SHALL map illegal state codes to RESET on the next edge.

Reset
REQ-031 SHALL, while reset is high, force the following immediately, independent of clk:
  - state=RESET, ball_num=0;
  - hit_valid=0, hit_hole=0, hit_mask=0;
  - group_lock=0, timeout=0;
  - synchronizer and dwell counter = 0.
REQ-032 SHALL, on reset asserted mid-round (START/GET), abandon the round with no hit_valid or timeout pulse, and resume from RESET after deassertion.

Verification (BALLS=2, SETTLE_CYCLES=4, LAUNCH_TIMEOUT=10)
REQ-033 SHALL verify the normal round. Stimulus: start_pulse, round_pulse, then ball=8'b0000_0100 held 1 cycle. Required response:
  - state 0->1->2->3, with GET reached 3 cycles after ball rises;
  - hit_valid one cycle, hit_hole=2, hit_mask=8'h04, ball_num=1;
  - GET lasts 4 cycles, then state=1.
REQ-034 SHALL verify simultaneous hits: ball=8'b1001_0000 in START -> hit_hole=4, hit_mask=8'h10.
REQ-035 SHALL verify timeout: no ball for 10 cycles in START -> timeout one cycle, ball_num 2->1, state=1.
REQ-036 SHALL verify game over: two consecutive rounds consume both balls -> state=4 after the second GET; round_pulse ignored; start_pulse -> state=0.
REQ-037 SHALL verify the blocked start: sball=8'h01 held in WAIT plus round_pulse -> state stays 1; release ball, round_pulse -> state=2.
REQ-038 SHALL verify mid-round reset: reset pulsed during GET cycle 2 -> all outputs at reset values within the same cycle; no hit_valid or timeout afterwards.

Source files
------------

// File: rtl/round_sequencer.sv
// Ball-drop game round sequencer: loads balls, arms a launch, latches the first
// hole hit (lowest index wins) or a launch timeout, and counts down balls.
module round_sequencer #(
  parameter int BALLS          = 8,
  parameter int SETTLE_CYCLES  = 200_000_000,
  parameter int LAUNCH_TIMEOUT = 1_000_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_pulse,
  input  logic       round_pulse,
  input  logic [7:0] ball,
  output logic [2:0] state,
  output logic [3:0] ball_num,
  output logic       hit_valid,
  output logic [2:0] hit_hole,
  output logic [7:0] hit_mask,
  output logic       group_lock,
  output logic       timeout
);

  localparam int MAX_DWELL = (SETTLE_CYCLES > LAUNCH_TIMEOUT) ? SETTLE_CYCLES : LAUNCH_TIMEOUT;
  localparam int CW        = $clog2(MAX_DWELL + 1);

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_WAIT  = 3'd1,
    S_START = 3'd2,
    S_GET   = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t        cur, nxt;
  logic [7:0]    meta, sball;
  logic [CW-1:0] dwell, dwell_next;
  logic          take_hit, take_timeout;
  logic [2:0]    low_idx;
  logic [3:0]    balls_dec;
  logic [3:0]    ball_num_next;
  logic [2:0]    hit_hole_next;
  logic [7:0]    hit_mask_next;
  logic          group_lock_next;

  assign state = cur;

  // Every flop, including the sensor synchronizer, lives here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur        <= S_RESET;
      meta       <= 8'd0;
      sball      <= 8'd0;
      dwell      <= '0;
      ball_num   <= 4'd0;
      hit_valid  <= 1'b0;
      hit_hole   <= 3'd0;
      hit_mask   <= 8'd0;
      group_lock <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      cur        <= nxt;
      meta       <= ball;
      sball      <= meta;
      dwell      <= dwell_next;
      ball_num   <= ball_num_next;
      hit_valid  <= take_hit;
      hit_hole   <= hit_hole_next;
      hit_mask   <= hit_mask_next;
      group_lock <= group_lock_next;
      timeout    <= take_timeout;
    end
  end

  always_comb begin
    low_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (sball[i]) low_idx = 3'(i);
    end
    balls_dec = (ball_num == 4'd0) ? 4'd0 : ball_num - 4'd1;
  end

  // A hit is checked before the timeout so it wins when both land together.
  always_comb begin
    nxt          = cur;
    take_hit     = 1'b0;
    take_timeout = 1'b0;
    case (cur)
      S_RESET: if (start_pulse) nxt = S_WAIT;
      S_WAIT:  if (round_pulse && (sball == 8'd0)) nxt = S_START;
      S_START: begin
        if (sball != 8'd0) begin
          take_hit = 1'b1;
          nxt      = S_GET;
        end else if (dwell == CW'(LAUNCH_TIMEOUT - 1)) begin
          take_timeout = 1'b1;
          nxt          = (balls_dec != 4'd0) ? S_WAIT : S_OVER;
        end
      end
      S_GET:   if (dwell == CW'(SETTLE_CYCLES - 1)) nxt = (ball_num != 4'd0) ? S_WAIT : S_OVER;
      S_OVER:  if (start_pulse) nxt = S_RESET;
      default: nxt = S_RESET;
    endcase
  end

  always_comb begin
    ball_num_next = ball_num;
    if ((cur == S_RESET) && start_pulse) ball_num_next = 4'(BALLS);
    else if (take_hit || take_timeout) ball_num_next = balls_dec;

    hit_hole_next = hit_hole;
    hit_mask_next = hit_mask;
    if ((cur == S_WAIT) && (nxt == S_START)) begin
      hit_hole_next = 3'd0;
      hit_mask_next = 8'd0;
    end else if (take_hit) begin
      hit_hole_next = low_idx;
      hit_mask_next = 8'd1 << low_idx;
    end

    group_lock_next = (nxt == S_START) || (nxt == S_GET);

    if ((nxt != cur) || !((cur == S_START) || (cur == S_GET))) dwell_next = '0;
    else dwell_next = dwell + CW'(1);
  end

endmodule

// File: tb/tb_round_sequencer.sv
// Self-checking bench for round_sequencer: cycle-level game model plus
// directed scenarios with hand-computed expectations.
module tb_round_sequencer;

  localparam int BALLS          = 2;
  localparam int SETTLE_CYCLES  = 4;
  localparam int LAUNCH_TIMEOUT = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_pulse = 1'b0;
  logic       round_pulse = 1'b0;
  logic [7:0] ball = 8'd0;
  logic [2:0] state;
  logic [3:0] ball_num;
  logic       hit_valid;
  logic [2:0] hit_hole;
  logic [7:0] hit_mask;
  logic       group_lock;
  logic       timeout;

  int pass_count  = 0;
  int check_count = 0;

  int m_state = 0, m_balls = 0, m_hv = 0, m_hh = 0, m_hm = 0, m_to = 0;
  int cyc = 0, entry = 0, hole = 0;
  logic [7:0] m_s1 = 8'd0, m_sb = 8'd0;

  round_sequencer #(
    .BALLS(BALLS),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .LAUNCH_TIMEOUT(LAUNCH_TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start_pulse(start_pulse),
    .round_pulse(round_pulse),
    .ball(ball),
    .state(state),
    .ball_num(ball_num),
    .hit_valid(hit_valid),
    .hit_hole(hit_hole),
    .hit_mask(hit_mask),
    .group_lock(group_lock),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    check_count++;
    if (actual == expected) pass_count++;
    else $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
  endtask

  task automatic applyStimulus(input logic sp, input logic rp, input logic [7:0] b);
    start_pulse = sp;
    round_pulse = rp;
    ball        = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 8'd0);
  endtask

  // Game model: sensors seen two edges late, dwell measured as cycles since entry.
  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_state = 0; m_balls = 0; m_hv = 0; m_hh = 0; m_hm = 0; m_to = 0;
        m_s1 = 8'd0; m_sb = 8'd0; entry = cyc;
      end else begin
        cyc++;
        m_hv = 0;
        m_to = 0;
        case (m_state)
          0: if (start_pulse) begin m_state = 1; m_balls = BALLS; entry = cyc; end
          1: if (round_pulse && m_sb == 8'd0) begin m_state = 2; m_hh = 0; m_hm = 0; entry = cyc; end
          2: begin
            if (m_sb != 8'd0) begin
              hole = lowest(m_sb);
              m_hh = hole;
              m_hm = 1 << hole;
              m_hv = 1;
              m_balls = (m_balls > 0) ? m_balls - 1 : 0;
              m_state = 3;
              entry = cyc;
            end else if (cyc - entry == LAUNCH_TIMEOUT) begin
              m_to = 1;
              m_balls = (m_balls > 0) ? m_balls - 1 : 0;
              m_state = (m_balls > 0) ? 1 : 4;
              entry = cyc;
            end
          end
          3: if (cyc - entry == SETTLE_CYCLES) begin m_state = (m_balls > 0) ? 1 : 4; entry = cyc; end
          4: if (start_pulse) begin m_state = 0; entry = cyc; end
          default: m_state = 0;
        endcase
        m_sb = m_s1;
        m_s1 = ball;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      checkOutput("model_state", int'(state), m_state);
      checkOutput("model_ball_num", int'(ball_num), m_balls);
      checkOutput("model_hit_valid", int'(hit_valid), m_hv);
      checkOutput("model_hit_hole", int'(hit_hole), m_hh);
      checkOutput("model_hit_mask", int'(hit_mask), m_hm);
      checkOutput("model_group_lock", int'(group_lock), (m_state == 2 || m_state == 3) ? 1 : 0);
      checkOutput("model_timeout", int'(timeout), m_to);
    end
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_state", int'(state), 0);
    checkOutput("reset_ball_num", int'(ball_num), 0);
    checkOutput("reset_hit_mask", int'(hit_mask), 0);
    reset = 1'b0;
    @(negedge clk);

    // Game 1: normal round on hole 2, then a simultaneous hit, then game over.
    applyStimulus(1'b1, 1'b0, 8'd0);
    checkOutput("load_state", int'(state), 1);
    checkOutput("load_ball_num", int'(ball_num), 2);
    applyStimulus(1'b0, 1'b1, 8'd0);
    checkOutput("arm_state", int'(state), 2);
    checkOutput("arm_group_lock", int'(group_lock), 1);
    applyStimulus(1'b0, 1'b0, 8'h04);
    applyStimulus(1'b0, 1'b0, 8'd0);
    checkOutput("sync_latency_state", int'(state), 2);
    applyStimulus(1'b0, 1'b0, 8'd0);
    checkOutput("hit_state", int'(state), 3);
    checkOutput("hit_valid", int'(hit_valid), 1);
    checkOutput("hit_hole", int'(hit_hole), 2);
    checkOutput("hit_mask", int'(hit_mask), 8'h04);
    checkOutput("hit_ball_num", int'(ball_num), 1);
    applyStimulus(1'b0, 1'b0, 8'd0);
    checkOutput("hit_valid_drop", int'(hit_valid), 0);
    idle(2);
    checkOutput("get_last_cycle", int'(state), 3);
    idle(1);
    checkOutput("get_exit_state", int'(state), 1);
    checkOutput("hole_hold", int'(hit_hole), 2);

    applyStimulus(1'b0, 1'b1, 8'd0);
    checkOutput("start_clears_mask", int'(hit_mask), 0);
    applyStimulus(1'b0, 1'b0, 8'h90);
    idle(2);
    checkOutput("prio_hole", int'(hit_hole), 4);
    checkOutput("prio_mask", int'(hit_mask), 8'h10);
    checkOutput("prio_ball_num", int'(ball_num), 0);
    idle(3);
    checkOutput("prio_get_state", int'(state), 3);
    idle(1);
    checkOutput("over_state", int'(state), 4);
    applyStimulus(1'b0, 1'b1, 8'd0);
    checkOutput("over_ignores_round", int'(state), 4);
    applyStimulus(1'b1, 1'b0, 8'd0);
    checkOutput("over_to_reset", int'(state), 0);

    // Game 2: blocked start, then a launch timeout, then reset mid-GET.
    applyStimulus(1'b1, 1'b0, 8'd0);
    checkOutput("reload_ball_num", int'(ball_num), 2);
    applyStimulus(1'b0, 1'b0, 8'h01);
    applyStimulus(1'b0, 1'b0, 8'h01);
    applyStimulus(1'b0, 1'b1, 8'h01);
    checkOutput("blocked_state", int'(state), 1);
    idle(2);
    applyStimulus(1'b0, 1'b1, 8'd0);
    checkOutput("unblocked_state", int'(state), 2);
    idle(9);
    checkOutput("pre_timeout_state", int'(state), 2);
    checkOutput("pre_timeout_pulse", int'(timeout), 0);
    idle(1);
    checkOutput("timeout_pulse", int'(timeout), 1);
    checkOutput("timeout_state", int'(state), 1);
    checkOutput("timeout_ball_num", int'(ball_num), 1);
    idle(1);
    checkOutput("timeout_drop", int'(timeout), 0);

    applyStimulus(1'b0, 1'b1, 8'd0);
    applyStimulus(1'b0, 1'b0, 8'h20);
    idle(2);
    checkOutput("last_hit_hole", int'(hit_hole), 5);
    checkOutput("last_hit_state", int'(state), 3);
    idle(1);
    #3 reset = 1'b1;
    #1;
    checkOutput("async_state", int'(state), 0);
    checkOutput("async_ball_num", int'(ball_num), 0);
    checkOutput("async_hit_valid", int'(hit_valid), 0);
    checkOutput("async_hit_hole", int'(hit_hole), 0);
    checkOutput("async_hit_mask", int'(hit_mask), 0);
    checkOutput("async_group_lock", int'(group_lock), 0);
    checkOutput("async_timeout", int'(timeout), 0);
    @(negedge clk);
    reset = 1'b0;
    idle(20);
    checkOutput("post_reset_state", int'(state), 0);
    checkOutput("post_reset_timeout", int'(timeout), 0);

    #2;
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
